// File: rtl/tt_vpu_pkg.sv
// Shared VPU types: store-drain FSM states and the buffered store request payload.
package tt_vpu_pkg;

  localparam int unsigned STORE_DATA_W = 32;
  localparam int unsigned STORE_ADDR_W = 48;
  localparam int unsigned STORE_BE_W   = STORE_DATA_W / 8;
  localparam int unsigned STORE_SZ_W   = 3;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    ORD_ISSUE = 2'd1,
    ORD_ACK   = 2'd2
  } drain_state_e;

  typedef struct packed {
    logic [STORE_ADDR_W-1:0] addr;
    logic [STORE_DATA_W-1:0] data;
    logic [STORE_BE_W-1:0]   byten;
    logic [STORE_SZ_W-1:0]   ldst_sz;
    logic                    ordered;
  } store_req_t;

endpackage

// File: rtl/tt_store_drain.sv
// Store FIFO consumer: pops entries into a one-deep request register, issues them to memory
// with req/gnt, tracks outstanding acks and serialises ordered stores around all other stores.
module tt_store_drain
  import tt_vpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = STORE_DATA_W,
  parameter int unsigned ADDR_WIDTH      = STORE_ADDR_W,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  output logic                    o_fifo_rden,
  input  logic                    i_fifo_valid,
  input  logic [DATA_WIDTH-1:0]   i_fifo_data,
  input  logic [ADDR_WIDTH-1:0]   i_fifo_addr,
  input  logic [DATA_WIDTH/8-1:0] i_fifo_byten,
  input  logic                    i_fifo_ordered,
  input  logic [2:0]              i_fifo_ldst_sz,
  output logic                    o_mem_req,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_data,
  output logic [DATA_WIDTH/8-1:0] o_mem_byten,
  output logic [2:0]              o_mem_ldst_sz,
  input  logic                    i_mem_gnt,
  input  logic                    i_mem_ack,
  output logic [CNT_W-1:0]        o_outstanding,
  output logic                    o_idle,
  output logic                    o_ack_underflow
);

  drain_state_e     state_q;
  drain_state_e     state_d;
  store_req_t       req_q;
  logic             req_vld_q;
  logic [CNT_W-1:0] count_q;
  logic             ack_underflow_q;
  logic             issue_ok;
  logic             issue;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state_q <= RUN;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:       if (i_fifo_valid && i_fifo_ordered) state_d = ORD_ISSUE;
      ORD_ISSUE: if (issue) state_d = ORD_ACK;
      ORD_ACK:   if (i_mem_ack && (count_q == CNT_W'(1))) state_d = RUN;
      default:   state_d = RUN;
    endcase
  end

  // Output logic; rden/req are gated by reset so nothing is popped or requested while held
  always_comb begin
    issue_ok    = 1'b0;
    o_mem_req   = 1'b0;
    issue       = 1'b0;
    o_fifo_rden = 1'b0;
    o_idle      = 1'b0;
    case (state_q)
      RUN:       issue_ok = (count_q < CNT_W'(MAX_OUTSTANDING));
      ORD_ISSUE: issue_ok = (count_q == '0);
      default:   issue_ok = 1'b0;
    endcase
    o_mem_req   = i_reset_n & req_vld_q & issue_ok;
    issue       = o_mem_req & i_mem_gnt;
    o_fifo_rden = i_reset_n & (state_q == RUN) & (~req_vld_q | (issue & ~req_q.ordered));
    o_idle      = ~req_vld_q & (count_q == '0) & (state_q == RUN);
  end

  // Request valid: a capture always wins, since the FIFO has already consumed that entry
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)        req_vld_q <= 1'b0;
    else if (i_fifo_valid) req_vld_q <= 1'b1;
    else if (issue)        req_vld_q <= 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_fifo_valid) begin
      req_q.addr    <= i_fifo_addr;
      req_q.data    <= i_fifo_data;
      req_q.byten   <= i_fifo_byten;
      req_q.ldst_sz <= i_fifo_ldst_sz;
      req_q.ordered <= i_fifo_ordered;
    end
  end

  // Outstanding write counter with sticky underflow flag
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      count_q         <= '0;
      ack_underflow_q <= 1'b0;
    end else begin
      case ({issue, i_mem_ack})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   if (count_q != '0) count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (i_mem_ack && !issue && (count_q == '0)) ack_underflow_q <= 1'b1;
    end
  end

  assign o_mem_addr      = req_q.addr;
  assign o_mem_data      = req_q.data;
  assign o_mem_byten     = req_q.byten;
  assign o_mem_ldst_sz   = req_q.ldst_sz;
  assign o_outstanding   = count_q;
  assign o_ack_underflow = ack_underflow_q;

`ifdef SIM
  // The FIFO may only present a consumed head while we are popping
  always_ff @(posedge i_clk) begin
    if (i_reset_n) assert (!(i_fifo_valid && !o_fifo_rden));
  end
`endif

endmodule

// File: tb/tb_tt_store_drain.sv
// Directed bench for tt_store_drain: the bench plays the store FIFO and the memory port.
module tb_tt_store_drain;
  import tt_vpu_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 48;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          i_reset_n;
  logic          o_fifo_rden;
  logic          i_fifo_valid;
  logic [DW-1:0] i_fifo_data;
  logic [AW-1:0] i_fifo_addr;
  logic [3:0]    i_fifo_byten;
  logic          i_fifo_ordered;
  logic [2:0]    i_fifo_ldst_sz;
  logic          o_mem_req;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_data;
  logic [3:0]    o_mem_byten;
  logic [2:0]    o_mem_ldst_sz;
  logic          i_mem_gnt;
  logic          i_mem_ack;
  logic [CW-1:0] o_outstanding;
  logic          o_idle;
  logic          o_ack_underflow;

  tt_store_drain dut (
    .i_clk           (clk),
    .i_reset_n       (i_reset_n),
    .o_fifo_rden     (o_fifo_rden),
    .i_fifo_valid    (i_fifo_valid),
    .i_fifo_data     (i_fifo_data),
    .i_fifo_addr     (i_fifo_addr),
    .i_fifo_byten    (i_fifo_byten),
    .i_fifo_ordered  (i_fifo_ordered),
    .i_fifo_ldst_sz  (i_fifo_ldst_sz),
    .o_mem_req       (o_mem_req),
    .o_mem_addr      (o_mem_addr),
    .o_mem_data      (o_mem_data),
    .o_mem_byten     (o_mem_byten),
    .o_mem_ldst_sz   (o_mem_ldst_sz),
    .i_mem_gnt       (i_mem_gnt),
    .i_mem_ack       (i_mem_ack),
    .o_outstanding   (o_outstanding),
    .o_idle          (o_idle),
    .o_ack_underflow (o_ack_underflow)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned n_issue = 0;

  store_req_t fifo_q[$];

  logic          obs_req, obs_issue, obs_rden, obs_idle, obs_uf;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_data;
  logic [3:0]    obs_byten;
  logic [CW-1:0] obs_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic ordered);
    store_req_t e;
    e.addr    = addr;
    e.data    = data;
    e.byten   = 4'hF;
    e.ldst_sz = 3'd2;
    e.ordered = ordered;
    fifo_q.push_back(e);
  endtask

  // One clock: drive gnt/ack, answer a pop from the queue, sample outputs before the edge.
  task automatic step(input logic gnt, input logic ack);
    logic popped;
    @(negedge clk);
    i_mem_gnt    = gnt;
    i_mem_ack    = ack;
    i_fifo_valid = 1'b0;
    #1;
    popped = 1'b0;
    if (o_fifo_rden && (fifo_q.size() != 0)) begin
      i_fifo_addr    = fifo_q[0].addr;
      i_fifo_data    = fifo_q[0].data;
      i_fifo_byten   = fifo_q[0].byten;
      i_fifo_ldst_sz = fifo_q[0].ldst_sz;
      i_fifo_ordered = fifo_q[0].ordered;
      i_fifo_valid   = 1'b1;
      popped         = 1'b1;
    end
    #1;
    obs_req   = o_mem_req;
    obs_issue = o_mem_req & gnt;
    obs_rden  = o_fifo_rden;
    obs_addr  = o_mem_addr;
    obs_data  = o_mem_data;
    obs_byten = o_mem_byten;
    obs_cnt   = o_outstanding;
    obs_idle  = o_idle;
    obs_uf    = o_ack_underflow;
    @(posedge clk);
    if (popped) void'(fifo_q.pop_front());
    if (obs_issue) n_issue++;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    i_reset_n    = 1'b0;
    i_mem_gnt    = 1'b0;
    i_mem_ack    = 1'b0;
    i_fifo_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_rst_rden"}, 64'(o_fifo_rden), 64'd0);
    chk({tag, "_rst_req"},  64'(o_mem_req),   64'd0);
    i_reset_n = 1'b1;
    #1;
    chk({tag, "_req"},  64'(o_mem_req),       64'd0);
    chk({tag, "_cnt"},  64'(o_outstanding),   64'd0);
    chk({tag, "_idle"}, 64'(o_idle),          64'd1);
    chk({tag, "_uf"},   64'(o_ack_underflow), 64'd0);
  endtask

  int unsigned maxcnt;
  int unsigned base_issue;

  initial begin
    i_reset_n      = 1'b0;
    i_fifo_valid   = 1'b0;
    i_fifo_data    = '0;
    i_fifo_addr    = '0;
    i_fifo_byten   = '0;
    i_fifo_ordered = 1'b0;
    i_fifo_ldst_sz = '0;
    i_mem_gnt      = 1'b0;
    i_mem_ack      = 1'b0;
    do_reset("init");

    // Streaming: four unordered stores, acks three cycles after each issue
    push(48'h100, 32'h1, 1'b0);
    push(48'h110, 32'h2, 1'b0);
    push(48'h120, 32'h3, 1'b0);
    push(48'h130, 32'h4, 1'b0);
    maxcnt = 0;
    for (int c = 0; c < 8; c++) begin
      step(1'b1, c >= 4);
      if (c <= 4) chk($sformatf("st_rden%0d", c), 64'(obs_rden), 64'd1);
      if (c == 0) chk("st_req0", 64'(obs_req), 64'd0);
      if (c >= 1 && c <= 4) begin
        chk($sformatf("st_req%0d", c), 64'(obs_req), 64'd1);
        chk($sformatf("st_addr%0d", c), 64'(obs_addr), 64'h100 + 64'(16 * (c - 1)));
      end
      if (int'(obs_cnt) > maxcnt) maxcnt = int'(obs_cnt);
    end
    step(1'b0, 1'b0);
    chk("st_maxcnt", 64'(maxcnt), 64'd3);
    chk("st_cnt_end", 64'(obs_cnt), 64'd0);
    chk("st_idle_end", 64'(obs_idle), 64'd1);

    // Outstanding limit: six stores, acks withheld
    for (int i = 0; i < 6; i++) push(48'h300 + 48'(16 * i), 32'(i), 1'b0);
    base_issue = n_issue;
    for (int c = 0; c < 7; c++) step(1'b1, 1'b0);
    chk("lim_issues", 64'(n_issue - base_issue), 64'd4);
    chk("lim_req", 64'(obs_req), 64'd0);
    chk("lim_rden", 64'(obs_rden), 64'd0);
    chk("lim_cnt", 64'(obs_cnt), 64'd4);
    step(1'b1, 1'b1);
    chk("lim_ack_same_cyc_req", 64'(obs_req), 64'd0);
    step(1'b1, 1'b0);
    chk("lim_5th_req", 64'(obs_req), 64'd1);
    chk("lim_5th_addr", 64'(obs_addr), 64'h340);
    step(1'b1, 1'b1);
    chk("lim_6th_blocked", 64'(obs_req), 64'd0);
    step(1'b1, 1'b0);
    chk("lim_6th_addr", 64'(obs_addr), 64'h350);
    for (int c = 0; c < 4; c++) step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("lim_idle", 64'(obs_idle), 64'd1);

    // Ordered fence between unordered stores
    push(48'h180, 32'h10, 1'b0);
    push(48'h190, 32'h11, 1'b0);
    push(48'h200, 32'h12, 1'b1);
    push(48'h210, 32'h13, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("ord_wait_req", 64'(obs_req), 64'd0);
    chk("ord_wait_rden", 64'(obs_rden), 64'd0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("ord_cnt1_req", 64'(obs_req), 64'd0);
    step(1'b1, 1'b0);
    chk("ord_issue_req", 64'(obs_req), 64'd1);
    chk("ord_issue_addr", 64'(obs_addr), 64'h200);
    chk("ord_issue_rden", 64'(obs_rden), 64'd0);
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b0);
      chk($sformatf("ord_ack_wait_rden%0d", c), 64'(obs_rden), 64'd0);
      chk($sformatf("ord_ack_wait_req%0d", c), 64'(obs_req), 64'd0);
    end
    step(1'b1, 1'b1);
    chk("ord_ackcyc_rden", 64'(obs_rden), 64'd0);
    step(1'b1, 1'b0);
    chk("ord_resume_rden", 64'(obs_rden), 64'd1);
    step(1'b1, 1'b0);
    chk("ord_next_addr", 64'(obs_addr), 64'h210);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("ord_idle", 64'(obs_idle), 64'd1);

    // Grant backpressure
    fifo_q.push_back('{addr: 48'h400, data: 32'hDEADBEEF, byten: 4'hF, ldst_sz: 3'd2, ordered: 1'b0});
    step(1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b0);
      chk($sformatf("bp_req%0d", c), 64'(obs_req), 64'd1);
      chk($sformatf("bp_data%0d", c), 64'(obs_data), 64'hDEADBEEF);
      chk($sformatf("bp_byten%0d", c), 64'(obs_byten), 64'hF);
      chk($sformatf("bp_rden%0d", c), 64'(obs_rden), 64'd0);
    end
    base_issue = n_issue;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("bp_one_issue", 64'(n_issue - base_issue), 64'd1);
    chk("bp_cnt", 64'(obs_cnt), 64'd1);
    step(1'b0, 1'b1);

    // Simultaneous issue and ack, then spurious ack
    push(48'h500, 32'h20, 1'b0);
    push(48'h510, 32'h21, 1'b0);
    push(48'h520, 32'h22, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("sim_issue", 64'(obs_issue), 64'd1);
    chk("sim_cnt_before", 64'(obs_cnt), 64'd2);
    step(1'b0, 1'b0);
    chk("sim_cnt_hold", 64'(obs_cnt), 64'd2);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("sim_cnt_zero", 64'(obs_cnt), 64'd0);
    chk("uf_pre", 64'(obs_uf), 64'd0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("uf_set", 64'(obs_uf), 64'd1);
    chk("uf_cnt", 64'(obs_cnt), 64'd0);
    step(1'b0, 1'b0);
    chk("uf_sticky", 64'(obs_uf), 64'd1);

    // Reset with three in flight and an ordered store waiting
    push(48'h600, 32'h30, 1'b0);
    push(48'h610, 32'h31, 1'b0);
    push(48'h620, 32'h32, 1'b0);
    push(48'h630, 32'h33, 1'b1);
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0);
    chk("mid_req", 64'(obs_req), 64'd0);
    chk("mid_cnt", 64'(obs_cnt), 64'd3);
    chk("mid_idle", 64'(obs_idle), 64'd0);
    do_reset("mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_store_drain.md
Name: tt_store_drain

Overview:
- Consumer end of the vector store FIFO.
- Pops store entries by asserting the FIFO read-enable and captures each popped entry into a one-entry request register.
- Issues each entry to the local/L1 memory port with a req/gnt handshake and tracks outstanding write acks.
- Enforces ordering: an ordered store issues only after all older stores are acked, and nothing younger issues until the ordered store itself is acked.

Parameters:
- DATA_WIDTH, 32, store data width in bits; byte-enable width is DATA_WIDTH/8.
- ADDR_WIDTH, 48, store address width.
- MAX_OUTSTANDING, 4, maximum granted-but-unacked writes (>=1).
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_reset_n  in  1  reset; synchronous, active-low.
- o_fifo_rden  out  1  pop request to the store FIFO.
- i_fifo_valid  in  1  FIFO head is valid and is consumed this cycle.
- i_fifo_data  in  DATA_WIDTH  store data.
- i_fifo_addr  in  ADDR_WIDTH  store address.
- i_fifo_byten  in  DATA_WIDTH/8  byte enables.
- i_fifo_ordered  in  1  ordered/fence store.
- i_fifo_ldst_sz  in  3  access size.
- o_mem_req  out  1  write request valid.
- o_mem_addr  out  ADDR_WIDTH  request address.
- o_mem_data  out  DATA_WIDTH  request data.
- o_mem_byten  out  DATA_WIDTH/8  request byte enables.
- o_mem_ldst_sz  out  3  request size.
- i_mem_gnt  in  1  request accepted this cycle.
- i_mem_ack  in  1  one write completed; at most one per cycle.
- o_outstanding  out  CNT_W  current unacked count.
- o_idle  out  1  high when the request register is empty, the count is 0 and the FSM is in RUN.
- o_ack_underflow  out  1  sticky error: an ack arrived while the count was 0.

Behaviour:
- Reset (i_reset_n=0 at a clock edge):
  - req_vld_q=0, count=0, FSM=RUN, o_ack_underflow=0.
  - Outputs: o_mem_req=0, o_fifo_rden=0, o_idle=1.
  - Data registers are not reset.
  - Reset mid-operation drops the held request and forgets in-flight acks.
- Handshake with the FIFO:
  - The FIFO consumes its head in any cycle where i_fifo_valid=1. That can only occur while o_fifo_rden=1.
  - The drain must therefore capture the entry unconditionally whenever i_fifo_valid=1.
  - i_fifo_valid=1 while o_fifo_rden=0 is a protocol error and is asserted under SIM.
- Request register:
  - When loaded, it holds addr, data, byten, ldst_sz and ordered.
  - o_mem_* are driven directly from the register.
  - o_mem_req = req_vld_q & issue_ok.
  - issue = o_mem_req & i_mem_gnt.
  - The request must stay stable while o_mem_req=1 and i_mem_gnt=0.
- issue_ok:
  - FSM is RUN or ORD_ISSUE.
  - In ORD_ISSUE, the count must also be 0.
  - count + 0 < MAX_OUTSTANDING, where the count is the registered value.
- o_fifo_rden:
  - o_fifo_rden = FSM==RUN & (~req_vld_q | (issue & ~req_ordered_q)).
  - This allows back-to-back entries at one per cycle.
  - There is a combinational path from i_mem_gnt to o_fifo_rden; this is accepted.
- Load:
  - If i_fifo_valid and the capture carries ordered=1, the FSM moves to ORD_ISSUE next cycle.
- FSM states:
  - RUN: normal streaming. Capturing an ordered entry goes to ORD_ISSUE.
  - ORD_ISSUE: no pops. Wait until count==0, then issue. On issue go to ORD_ACK.
  - ORD_ACK: no pops, no requests. When i_mem_ack and count==1, go to RUN.
- Outstanding counter:
  - +1 on issue, -1 on i_mem_ack.
  - Issue and ack in the same cycle: the count holds.
  - An ack with count==0: the count stays 0 and o_ack_underflow is set, cleared only by reset.
  - The count never exceeds MAX_OUTSTANDING.
- Latency: i_fifo_valid at cycle N gives o_mem_req at N+1 at the earliest. For ordered entries, o_mem_req waits for count==0.
- Boundary conditions:
  - Count at the limit with the register full: o_mem_req=0 and o_fifo_rden=0 until an ack arrives.
  - An ack arriving in the same cycle as the limit does not unblock until the next cycle (registered count).

Decomposition:
- tt_vpu_pkg gains:
  - drain_state_e {RUN, ORD_ISSUE, ORD_ACK}.
  - A store_req_t struct {addr, data, byten, ldst_sz, ordered}, parameterised through localparams.
- Single module; no sub-module.
- The counter is inline.

Test Plan:
- Streaming: 4 unordered stores (addr 0x100,0x110,0x120,0x130), gnt always 1, acks 3 cycles later -> rden held high, o_mem_req on 4 consecutive cycles, max o_outstanding=3, final count 0, o_idle=1.
- Outstanding limit: MAX_OUTSTANDING=4, gnt=1, acks withheld, 6 stores -> exactly 4 issues, then o_mem_req=0 and rden=0. One ack -> the 5th issues the next cycle.
- Ordered fence: 2 unordered stores outstanding, then an ordered store at 0x200 -> 0x200 not requested until count=0. After its issue, no pops until its ack. The following store appears only after the ack.
- Gnt backpressure: gnt=0 for 5 cycles with data 0xDEADBEEF and byten 0xF -> o_mem_* stable, rden=0. gnt=1 -> single issue, count=1.
- Simultaneous issue+ack at count=2 -> count stays 2. Spurious ack at count=0 -> o_ack_underflow=1 and sticky, count remains 0.
- Reset mid-operation with count=3 and the FSM in ORD_ISSUE -> next cycle: o_mem_req=0, count=0, FSM=RUN, o_idle=1, o_ack_underflow=0.
